// File: rtl/host_cmd_frontend_pkg.sv
// Shared definitions for the host command front end.
// Holds the command opcodes, response status codes, the FSM state type and
// the field width used by the byte shifters.
package host_cmd_frontend_pkg;

  localparam int BLOCK_W = 128;

  localparam logic [7:0] CMD_SET_KEY = 8'h01;
  localparam logic [7:0] CMD_XFER    = 8'h02;
  localparam logic [7:0] CMD_SET_MAX = 8'h03;

  localparam logic [7:0] ST_OK       = 8'h00;
  localparam logic [7:0] ST_BADCMD   = 8'hE1;
  localparam logic [7:0] ST_TIMEOUT  = 8'hEE;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RX_KEY,
    S_RX_ACC,
    S_RX_PWD,
    S_RX_MAX,
    S_GO,
    S_WAIT,
    S_TX_STAT,
    S_TX_DATA
  } state_t;

endpackage

// File: rtl/host_cmd_frontend_byte_shift128.sv
// byte_shift128: 128-bit byte-wide shift register with parallel load and a
// 4-bit byte counter. Used both to assemble incoming fields (first byte ends
// up in the top byte) and to serialise the result MSB byte first.
// Ports:
//   clk, rst        clock, async active-high reset (clears data and count)
//   load, load_data parallel load; also restarts the byte count
//   shift_en        shift data left by one byte, shift_in enters at [7:0]
//   data            current register contents
//   last            byte count is 15: the next shift completes 16 bytes
module byte_shift128
  import host_cmd_frontend_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [BLOCK_W-1:0] load_data,
  input  logic               shift_en,
  input  logic [7:0]         shift_in,
  output logic [BLOCK_W-1:0] data,
  output logic               last
);

  logic [3:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
      cnt  <= 4'd0;
    end else if (load) begin
      data <= load_data;
      cnt  <= 4'd0;
    end else if (shift_en) begin
      data <= {data[BLOCK_W-9:0], shift_in};
      // wraps to 0 on the 16th byte, ready for the next field
      cnt  <= cnt + 4'd1;
    end
  end

  assign last = (cnt == 4'hF);

endmodule

// File: rtl/host_cmd_frontend.sv
// host_cmd_frontend: byte-stream command front end for the password manager.
// Collects key / account / password / max_address from the host, pulses go,
// waits for done and returns a status byte plus (on success) the 16-byte
// encrypted result.
// Ports:
//   clk, rst                  clock, async active-high reset
//   rx_data/rx_valid/rx_ready host -> front end byte stream
//   tx_data/tx_valid/tx_ready front end -> host byte stream
//   master_key, account, password, max_address  fields to the top level
//   go, done, password_enc    start pulse, completion, result
//   busy                      high whenever not idle
//
// state     | meaning
// ----------+--------------------------------------------------
// S_IDLE    | waiting for a command byte
// S_RX_KEY  | collecting 16 key bytes
// S_RX_ACC  | collecting 16 account bytes
// S_RX_PWD  | collecting 16 password bytes
// S_RX_MAX  | collecting the single max_address byte
// S_GO      | go pulse high, timeout counter cleared
// S_WAIT    | waiting for a rising edge on done, or timeout
// S_TX_STAT | presenting the status byte
// S_TX_DATA | presenting the 16 result bytes, MSB first
module host_cmd_frontend
  import host_cmd_frontend_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 13
)
(
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic [127:0] master_key,
  output logic [127:0] account,
  output logic [127:0] password,
  output logic [3:0]   max_address,
  output logic         go,
  input  logic         done,
  input  logic [127:0] password_enc,
  output logic         busy
);

  state_t             state;
  logic [CNT_W-1:0]   tmo_cnt;
  logic               done_q;
  logic               payload;

  logic               rx_fire;
  logic               tx_fire;
  logic               done_rise;
  logic               key_last, acc_last, pwd_last, ser_last;
  logic [BLOCK_W-1:0] ser_data;
  // only the top two bytes of the serialiser feed tx_data
  logic [BLOCK_W-17:0] ser_unused;

  // rx_ready is forced low during reset, not just once the state settles
  assign rx_ready  = ~rst & ((state == S_IDLE)   || (state == S_RX_KEY) ||
                             (state == S_RX_ACC) || (state == S_RX_PWD) ||
                             (state == S_RX_MAX));
  assign rx_fire   = rx_valid & rx_ready;
  assign tx_fire   = tx_valid & tx_ready;
  assign done_rise = done & ~done_q;
  assign busy      = (state != S_IDLE);
  assign ser_unused = ser_data[BLOCK_W-17:0];

  // Fields shift straight into their output registers.
  byte_shift128 u_key (
    .clk       (clk),
    .rst       (rst),
    .load      (1'b0),
    .load_data ('0),
    .shift_en  ((state == S_RX_KEY) & rx_fire),
    .shift_in  (rx_data),
    .data      (master_key),
    .last      (key_last)
  );

  byte_shift128 u_acc (
    .clk       (clk),
    .rst       (rst),
    .load      (1'b0),
    .load_data ('0),
    .shift_en  ((state == S_RX_ACC) & rx_fire),
    .shift_in  (rx_data),
    .data      (account),
    .last      (acc_last)
  );

  byte_shift128 u_pwd (
    .clk       (clk),
    .rst       (rst),
    .load      (1'b0),
    .load_data ('0),
    .shift_en  ((state == S_RX_PWD) & rx_fire),
    .shift_in  (rx_data),
    .data      (password),
    .last      (pwd_last)
  );

  byte_shift128 u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      ((state == S_WAIT) & done_rise),
    .load_data (password_enc),
    .shift_en  ((state == S_TX_DATA) & tx_fire),
    .shift_in  (8'h00),
    .data      (ser_data),
    .last      (ser_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      tmo_cnt     <= '0;
      done_q      <= 1'b0;
      payload     <= 1'b0;
      max_address <= 4'h0;
      go          <= 1'b0;
      tx_data     <= 8'h00;
      tx_valid    <= 1'b0;
    end else begin
      done_q <= done;
      go     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_fire) begin
            case (rx_data)
              CMD_SET_KEY: state <= S_RX_KEY;
              CMD_XFER:    state <= S_RX_ACC;
              CMD_SET_MAX: state <= S_RX_MAX;
              default: begin
                tx_data  <= ST_BADCMD;
                tx_valid <= 1'b1;
                state    <= S_TX_STAT;
              end
            endcase
          end
        end
        S_RX_KEY: begin
          if (rx_fire && key_last) begin
            tx_data  <= ST_OK;
            tx_valid <= 1'b1;
            state    <= S_TX_STAT;
          end
        end
        S_RX_MAX: begin
          if (rx_fire) begin
            max_address <= rx_data[3:0];
            tx_data     <= ST_OK;
            tx_valid    <= 1'b1;
            state       <= S_TX_STAT;
          end
        end
        S_RX_ACC: begin
          if (rx_fire && acc_last) state <= S_RX_PWD;
        end
        S_RX_PWD: begin
          if (rx_fire && pwd_last) begin
            go    <= 1'b1;
            state <= S_GO;
          end
        end
        S_GO: begin
          tmo_cnt <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          // a done edge on the timeout cycle still counts as success
          if (done_rise) begin
            payload  <= 1'b1;
            tx_data  <= ST_OK;
            tx_valid <= 1'b1;
            state    <= S_TX_STAT;
          end else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            tx_data  <= ST_TIMEOUT;
            tx_valid <= 1'b1;
            state    <= S_TX_STAT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_TX_STAT: begin
          if (tx_fire) begin
            if (payload) begin
              tx_data <= ser_data[BLOCK_W-1 -: 8];
              state   <= S_TX_DATA;
            end else begin
              tx_valid <= 1'b0;
              state    <= S_IDLE;
            end
          end
        end
        S_TX_DATA: begin
          if (tx_fire) begin
            if (ser_last) begin
              tx_valid <= 1'b0;
              payload  <= 1'b0;
              state    <= S_IDLE;
            end else begin
              // byte that becomes the top byte after this shift
              tx_data <= ser_data[BLOCK_W-9 -: 8];
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/host_cmd_frontend.md
Name: host_cmd_frontend

Overview:
- Byte-stream command front end directly upstream of the password-manager top level.
- Receives host commands over an 8-bit valid/ready stream and assembles the 128-bit master_key, account and password fields plus max_address.
- Pulses go, waits for done, then returns password_enc to the host as a status byte followed by 16 bytes.

Parameters:
- TIMEOUT_CYCLES, 4096: cycles allowed in WAIT before the operation is aborted; minimum 2.
- CNT_W, 13: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- rx_data  in  8  host command/payload byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  front end accepts rx byte
- tx_data  out  8  response byte to host
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  host accepts tx byte
- master_key  out  128  key to top level
- account  out  128  account name to top level
- password  out  128  plaintext password to top level
- max_address  out  4  highest flash address in use
- go  out  1  one-cycle start pulse to top level
- done  in  1  top-level completion (level or pulse)
- password_enc  in  128  top-level result
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, immediate): state=IDLE; master_key, account, password, tx_data = 0; max_address=0; go=0; tx_valid=0; rx_ready=0 while rst is high.
- Accept rule: a byte is taken on a cycle with rx_valid & rx_ready. rx_ready=1 only in IDLE, RX_KEY, RX_ACC, RX_PWD and RX_MAX; 0 otherwise.
- Field assembly: the first payload byte lands in [127:120]: field <= {field[119:0], rx_data}. A 4-bit byte counter counts 0..15; the accepted byte at count 15 completes the field.
- IDLE, command byte:
  - 0x01 -> RX_KEY
  - 0x02 -> RX_ACC
  - 0x03 -> RX_MAX
  - any other value -> load status 0xE1 and go to TX_STAT (no payload).
- RX_KEY: after 16 bytes, load status 0x00 -> TX_STAT (ack only).
- RX_MAX: one byte; max_address <= rx_data[3:0]; load status 0x00 -> TX_STAT.
- RX_ACC: 16 bytes -> RX_PWD. RX_PWD: 16 bytes -> GO.
- GO: go=1 for exactly one cycle -> WAIT; clear the timeout counter.
- WAIT:
  - done_q is a registered copy of done. Completion is the rising edge done & ~done_q, so a level done left high from a previous operation is ignored.
  - On completion: capture password_enc into result reg; status 0x00; set payload flag -> TX_STAT.
  - If the counter reaches TIMEOUT_CYCLES-1 with no edge: status 0xEE, no payload -> TX_STAT.
  - If an edge and the timeout coincide, the edge wins.
- TX_STAT: tx_valid=1 with the status byte. tx_data and tx_valid are held stable until tx_ready. After the handshake: if payload flag set -> TX_DATA, else -> IDLE.
- TX_DATA: sends 16 bytes of the result reg MSB byte first (shift left by 8 per handshake). After the 16th handshake -> IDLE and clear payload flag.
- Outputs master_key, account, password and max_address hold their values between commands. A new 0x01 command overwrites the key.
- done outside WAIT is ignored except for updating done_q.
- Mid-operation reset: all state is cleared immediately. Partial fields are zeroed and no go or tx is emitted afterwards.
- busy is combinational: busy = (state != IDLE).

Decomposition:
- Shared package (pk_defs): command opcodes CMD_SET_KEY=8'h01, CMD_XFER=8'h02, CMD_SET_MAX=8'h03; status codes ST_OK=8'h00, ST_BADCMD=8'hE1, ST_TIMEOUT=8'hEE; state enum; BLOCK_W=128.
- One sub-module, byte_shift128: a 128-bit shift register with load-enable and a 4-bit byte counter with a last-byte flag. It is instantiated for field assembly and for the tx result serializer.

Test Plan:
- Set key: send 0x01 then bytes f2 56 84 7d ae a3 9d a5 d8 70 ad f5 69 71 23 60 -> master_key=128'hf256847daea39da5d870adf569712360; tx emits single byte 0x00; busy returns low.
- Transfer: send 0x02, 16×0xaa, then password bytes; model drives done high 10 cycles after go and password_enc=128'h0123456789abcdef0011223344556677 -> exactly one go pulse; tx emits 0x00,01,23,...,77 (17 bytes).
- Backpressure: tx_ready toggles 1-0-0-1 randomly and rx_valid has gaps -> bytes neither dropped nor duplicated; tx_data stable while tx_valid & ~tx_ready.
- Timeout/stale done: done held high before go and never toggles -> after TIMEOUT_CYCLES, tx emits only 0xEE; state returns to IDLE.
- Bad command and max_address: send 0x7f -> tx 0xE1. Send 0x03, 0x3c -> max_address=4'hc and tx 0x00.
- Reset mid-RX_ACC after 7 bytes -> all outputs 0 at once; a fresh 0x02 transfer then completes correctly.
